uart_rx0: RTL
=============

Name: uart_rx0

Overview:
- Serial receiver counterpart to the logger's 8N1 UART transmitter; shares the same 16x oversample `enable` tick from the baud generator.
- Synchronises the `ser_in` line, detects and qualifies the start bit, then samples 8 data bits LSB-first and checks the stop bit.
- Presents each received byte to the logger core with a held-valid/acknowledge handshake, plus framing and overrun error pulses.

Parameters:
- OVERSAMPLE, 16, `enable` ticks per bit; must be a power of two, at least 8.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  oversample tick, one clk wide, OVERSAMPLE per bit period
- ser_in  in  1  raw serial line; idle high; asynchronous to clk
- rd_ack  in  1  core has consumed dout_byte; clears dout_rdy
- dout_byte  out  8  last good received byte
- dout_rdy  out  1  level; byte waiting in dout_byte
- frame_err  out  1  one-clk pulse: stop bit sampled 0
- overrun  out  1  one-clk pulse: new byte written while dout_rdy=1
- rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: dout_byte=0, dout_rdy=0, frame_err=0, overrun=0, rx_busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: ser_in passes through 2 flops to give rx_s. All decisions use rx_s only. Input-to-decision latency is 2 clk.
- The sample counter (width log2(OVERSAMPLE)) advances only on `enable`. It clears on every state entry.
- IDLE:
  - if rx_s=0 on an enable tick, go to START.
- START:
  - at count OVERSAMPLE/2-1, re-sample rx_s.
  - if rx_s=0, go to DATA and clear the counter; the mid-bit is now aligned.
  - if rx_s=1, treat as a glitch and return to IDLE silently.
- DATA:
  - at each count OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift, so bits end up LSB-first).
  - a bit counter runs 0..7; after the 8th sample go to STOP (or PARITY when the feature is enabled).
- STOP:
  - sample at count OVERSAMPLE-1.
  - if rx_s=1: load dout_byte, set dout_rdy. If dout_rdy was already 1 in that cycle, pulse overrun; the new byte overwrites.
  - if rx_s=0: pulse frame_err; dout_byte and dout_rdy are unchanged.
  - either way, return to IDLE in the same clock.
  - a break condition (line held low) must not be re-detected as a start until rx_s has returned high for at least one enable tick. IDLE therefore arms only after seeing rx_s=1.
- Handshake:
  - rd_ack=1 clears dout_rdy on the next clk.
  - if rd_ack and a byte load coincide, the load wins: dout_rdy stays 1 and no overrun is flagged.
- enable=0 freezes all counters; the state is held.
- Asynchronous rst mid-frame aborts the frame immediately. No error pulse is generated.
- Latency: dout_rdy rises 1 clk after the stop-bit mid-sample tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - adds a PARITY state between DATA and STOP, sampled at count OVERSAMPLE-1.
  - adds output port parity_err (1-bit pulse).
  - on mismatch against the PARITY_ODD sense: pulse parity_err and do not load the byte. STOP is still checked.
- Undefined:
  - 8N1 only; no PARITY state, no parity_err port.

Decomposition:
- Package uart_pkg:
  - state encodings IDLE=0, START=1, DATA=2, STOP=3, PARITY=4 (3-bit state type).
  - OVERSAMPLE default constant, DATA_BITS=8.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset-to-1 and an optional 3-sample majority vote. It is natural to share with future inputs.

Test Plan:
- Byte 0xA5, 8N1, 16 ticks/bit, rd_ack after 5 clk -> dout_byte=0xA5, dout_rdy high until the clk after rd_ack, no errors.
- 0.25-bit low glitch on idle ser_in -> returns to IDLE from START, dout_rdy stays 0, rx_busy pulses then falls, no frame_err.
- Byte 0x3C with the stop bit forced 0 -> frame_err one-clk pulse, dout_byte retains the previous value 0xA5, dout_rdy unchanged.
- Two back-to-back bytes 0x11 then 0x22 with no rd_ack -> overrun pulse on the second load, dout_byte=0x22, dout_rdy=1.
- rst asserted mid-DATA during byte 0xFF, then byte 0x5A sent -> all outputs at reset values during rst; 0x5A then received cleanly.
- With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 0 -> parity_err pulse, no load; 0x07 with parity bit 1 -> dout_byte=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS      = 8;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input, reset to the idle-high level.
// MAJORITY=1 adds a 3-sample vote after the synchroniser to reject single-clk spikes.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter bit MAJORITY = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (MAJORITY) begin : g_vote
    logic [3:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '1;
      else       sync_q <= {sync_q[2:0], d_i};
    end
    assign q_o = maj3(sync_q[3:1]);
  end else begin : g_plain
    logic [1:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '1;
      else       sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
  end

endmodule

// File: rtl/uart_rx0.sv
// Oversampling UART receiver (8N1) with held-valid/ack byte handshake.
// Define UART_RX_PARITY_EN to add a parity bit (sense from PARITY_ODD) and parity_err_o.
module uart_rx0
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       ser_in_i,
  input  logic       rd_ack_i,
  output logic [7:0] dout_byte_o,
  output logic       dout_rdy_o,
  output logic       frame_err_o,
  output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       rx_busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [7:0]             byte_q, byte_d;
  logic                   armed_q, armed_d;
  logic                   rdy_q, rdy_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   load;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d;
  logic                   par_bad_q, par_bad_d;
`endif

  uart_rx_sync #(.MAJORITY(1'b0)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ser_in_i),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      armed_q   <= 1'b0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      armed_q   <= armed_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    armed_d   = armed_q;
    rdy_d     = rdy_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    load      = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    if (enable_i) begin
      case (state_q)
        // Arming needs a high tick first so a held-low break is not re-taken as a start.
        ST_IDLE: begin
          if (armed_q && !rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_STOP;
            if (((^shift_q) ^ rx_s) != PARITY_ODD) begin
              perr_d    = 1'b1;
              par_bad_d = 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              load = !par_bad_q;
`else
              load = 1'b1;
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // A load in the same clk as rd_ack wins and is not an overrun.
    if (load) begin
      byte_d = shift_q;
      rdy_d  = 1'b1;
      ovr_d  = rdy_q && !rd_ack_i;
    end else if (rd_ack_i) begin
      rdy_d = 1'b0;
    end
  end

  assign dout_byte_o  = byte_q;
  assign dout_rdy_o   = rdy_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign rx_busy_o    = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule
